// File: rtl/recoded_float64_to_any_seq.sv
// Multi-cycle converter from recoded float64 to uint32/int32/uint64/int64 with valid/ready on both sides.
// Define RECF64_TO_ANY_BARREL_EN to replace the iterative SHIFT state with a full barrel shift at accept.
module recoded_float64_to_any_seq #(
  parameter int SHIFT_STEP = 8,
  parameter int INT_WIDTH  = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [64:0]          in,
  input  logic [1:0]           roundingMode,
  input  logic [1:0]           typeOp,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [INT_WIDTH-1:0] out,
  output logic [4:0]           exceptionFlags
);

  localparam int ACC_W = INT_WIDTH + 52;

  localparam logic [1:0] RM_NEAR_EVEN = 2'd0;
  localparam logic [1:0] RM_MIN_MAG   = 2'd1;
  localparam logic [1:0] RM_MIN       = 2'd2;

  localparam logic [1:0] TYPE_UINT32 = 2'd0;
  localparam logic [1:0] TYPE_INT32  = 2'd1;
  localparam logic [1:0] TYPE_UINT64 = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ROUND,
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic signed [12:0] e_q, e_d;
  logic               sign_q, sign_d;
  logic               zero_q, zero_d;
  logic               inf_q, inf_d;
  logic               nan_q, nan_d;
  logic [1:0]         typ_q, typ_d;
  logic [1:0]         rm_q, rm_d;
  logic [63:0]        out_q, out_d;
  logic [4:0]         flags_q, flags_d;

`ifndef RECF64_TO_ANY_BARREL_EN
  localparam logic [6:0] STEP = 7'(SHIFT_STEP);
  logic [6:0] cnt_q, cnt_d;
  logic [6:0] sh;
  assign sh = (cnt_q < STEP) ? cnt_q : STEP;
`endif

  // Operand decode used only on the accept cycle.
  logic [2:0]         in_cls;
  logic signed [12:0] in_e;
  logic               in_special;
  logic               in_shift;
  logic [ACC_W-1:0]   in_acc;

  assign in_cls     = in[63:61];
  assign in_e       = $signed({1'b0, in[63:52]}) - 13'sd2048;
  assign in_special = (in_cls == 3'b000) || (in_cls[2:1] == 2'b11);
  assign in_shift   = !in_special && (in_e > 13'sd0) && (in_e < 13'sd64);
  assign in_acc     = {{(INT_WIDTH-1){1'b0}}, 1'b1, in[51:0]};

  // Rounding and range check, evaluated from the registered operand during ROUND.
  logic [63:0] int_v;
  logic        guard;
  logic        sticky;
  logic        inc;
  logic [64:0] mag;
  logic        in_range;
  logic        invalid;
  logic [63:0] res_inv;
  logic [63:0] res_val;
  logic [63:0] res_pre;
  logic [63:0] res;

  // NOTE: every signal written in an always_comb gets a value on every path first, so no latches.
  always_comb begin
    int_v  = acc_q[ACC_W-1:52];
    guard  = acc_q[51];
    sticky = |acc_q[50:0];
    if (zero_q) begin
      int_v  = '0;
      guard  = 1'b0;
      sticky = 1'b0;
    end else if (e_q < 13'sd0) begin
      int_v = '0;
      if (e_q == -13'sd1) begin
        guard  = 1'b1;
        sticky = |acc_q[51:0];
      end else begin
        guard  = 1'b0;
        sticky = 1'b1;
      end
    end

    case (rm_q)
      RM_NEAR_EVEN: inc = guard & (sticky | int_v[0]);
      RM_MIN_MAG:   inc = 1'b0;
      RM_MIN:       inc = sign_q & (guard | sticky);
      default:      inc = ~sign_q & (guard | sticky);
    endcase

    mag = {1'b0, int_v} + {64'd0, inc};

    case (typ_q)
      TYPE_UINT32: in_range = (!sign_q || mag == '0) && (mag <= 65'h0_FFFF_FFFF);
      TYPE_INT32:  in_range = sign_q ? (mag <= 65'h0_8000_0000) : (mag <= 65'h0_7FFF_FFFF);
      TYPE_UINT64: in_range = (!sign_q || mag == '0) && !mag[64];
      default:     in_range = sign_q ? (mag <= 65'h0_8000_0000_0000_0000)
                                     : (mag <= 65'h0_7FFF_FFFF_FFFF_FFFF);
    endcase

    invalid = nan_q || inf_q || (!zero_q && (e_q > 13'sd63)) || !in_range;

    // Saturation target: type max for NaN or positive, type min for negative.
    if (nan_q || !sign_q) begin
      case (typ_q)
        TYPE_UINT32: res_inv = 64'h0000_0000_FFFF_FFFF;
        TYPE_INT32:  res_inv = 64'h0000_0000_7FFF_FFFF;
        TYPE_UINT64: res_inv = 64'hFFFF_FFFF_FFFF_FFFF;
        default:     res_inv = 64'h7FFF_FFFF_FFFF_FFFF;
      endcase
    end else begin
      case (typ_q)
        TYPE_INT32: res_inv = 64'h0000_0000_8000_0000;
        2'd3:       res_inv = 64'h8000_0000_0000_0000;
        default:    res_inv = 64'd0;
      endcase
    end

    res_val = sign_q ? (64'd0 - mag[63:0]) : mag[63:0];
    res_pre = invalid ? res_inv : res_val;
    res     = typ_q[1] ? res_pre : {{32{res_pre[31]}}, res_pre[31:0]};
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    e_d     = e_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    inf_d   = inf_q;
    nan_d   = nan_q;
    typ_d   = typ_q;
    rm_d    = rm_q;
    out_d   = out_q;
    flags_d = flags_q;
`ifndef RECF64_TO_ANY_BARREL_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d = in[64];
          e_d    = in_e;
          zero_d = (in_cls == 3'b000);
          inf_d  = (in_cls == 3'b110);
          nan_d  = (in_cls == 3'b111);
          typ_d  = typeOp;
          rm_d   = roundingMode;
`ifdef RECF64_TO_ANY_BARREL_EN
          acc_d   = in_shift ? (in_acc << in_e[5:0]) : in_acc;
          state_d = ROUND;
`else
          acc_d   = in_acc;
          cnt_d   = in_e[6:0];
          state_d = in_shift ? SHIFT : ROUND;
`endif
        end
      end
`ifndef RECF64_TO_ANY_BARREL_EN
      SHIFT: begin
        acc_d = acc_q << sh;
        cnt_d = cnt_q - sh;
        if (cnt_d == 7'd0) state_d = ROUND;
      end
`endif
      ROUND: begin
        out_d   = res;
        flags_d = invalid ? 5'b10000 : {4'b0000, guard | sticky};
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      e_q     <= '0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      inf_q   <= 1'b0;
      nan_q   <= 1'b0;
      typ_q   <= '0;
      rm_q    <= '0;
      out_q   <= '0;
      flags_q <= '0;
`ifndef RECF64_TO_ANY_BARREL_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      e_q     <= e_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      inf_q   <= inf_d;
      nan_q   <= nan_d;
      typ_q   <= typ_d;
      rm_q    <= rm_d;
      out_q   <= out_d;
      flags_q <= flags_d;
`ifndef RECF64_TO_ANY_BARREL_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign in_ready       = (state_q == IDLE);
  assign out_valid      = (state_q == DONE);
  assign out            = out_q;
  assign exceptionFlags = flags_q;

endmodule

// File: tb/tb_recoded_float64_to_any_seq.sv
// Scoreboard bench for recoded_float64_to_any_seq: directed corner cases plus random operands
// checked against an arithmetic reference model; a separate monitor checks every result.
module tb_recoded_float64_to_any_seq;

  localparam int STEP = 8;

  localparam logic [1:0] RNE   = 2'd0;
  localparam logic [1:0] RMAG  = 2'd1;
  localparam logic [1:0] RMIN  = 2'd2;
  localparam logic [1:0] RMAX  = 2'd3;
  localparam logic [1:0] T_U32 = 2'd0;
  localparam logic [1:0] T_I32 = 2'd1;
  localparam logic [1:0] T_U64 = 2'd2;
  localparam logic [1:0] T_I64 = 2'd3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [64:0] in_op = '0;
  logic [1:0]  rm = '0;
  logic [1:0]  typ = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out;
  logic [4:0]  flags;

  recoded_float64_to_any_seq #(.SHIFT_STEP(STEP), .INT_WIDTH(64)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in             (in_op),
    .roundingMode   (rm),
    .typeOp         (typ),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out            (out),
    .exceptionFlags (flags)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [63:0] out;
    logic [4:0]  flags;
    int          lat;
    int unsigned acc_cyc;
  } exp_t;

  exp_t expq[$];
  int   force_hold = 0;
  bit   mon_busy = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    compared++;
    if (act !== want) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Reference: exact value mant*2^(e-52) held as a fixed-point number with 53 fraction bits.
  function automatic exp_t model(input logic [64:0] op, input logic [1:0] rmode, input logic [1:0] t);
    exp_t               r;
    logic               sgn, nan, inf, zero, up, invalid, inexact;
    logic [11:0]        ex;
    int                 e;
    logic [127:0]       fx, ip, rem, half;
    logic signed [71:0] lo, hi, v, pick;
    logic [63:0]        o;
    sgn  = op[64];
    ex   = op[63:52];
    nan  = (ex[11:9] == 3'b111);
    inf  = (ex[11:9] == 3'b110);
    zero = (ex[11:9] == 3'b000);
    e    = int'(ex) - 2048;
    case (t)
      T_U32:   begin lo = 72'sd0; hi = 72'sh0_FFFF_FFFF; end
      T_I32:   begin lo = -72'sh8000_0000; hi = 72'sh7FFF_FFFF; end
      T_U64:   begin lo = 72'sd0; hi = 72'sh0_FFFF_FFFF_FFFF_FFFF; end
      default: begin lo = -72'sh8000_0000_0000_0000; hi = 72'sh7FFF_FFFF_FFFF_FFFF; end
    endcase
    invalid = 1'b0;
    inexact = 1'b0;
    v       = 72'sd0;
    if (nan || inf || (!zero && e >= 64)) begin
      invalid = 1'b1;
    end else if (!zero) begin
      half = 128'd1 << 52;
      if (e >= -1) begin
        fx  = {75'd0, 1'b1, op[51:0]} << (e + 1);
        ip  = fx >> 53;
        rem = fx & ((128'd1 << 53) - 128'd1);
      end else begin
        ip  = 128'd0;
        rem = 128'd1;
      end
      case (rmode)
        RNE:     up = (rem > half) || ((rem == half) && ip[0]);
        RMAG:    up = 1'b0;
        RMIN:    up = sgn && (rem != 0);
        default: up = !sgn && (rem != 0);
      endcase
      ip = ip + {127'd0, up};
      v  = $signed(ip[71:0]);
      if (sgn) v = -v;
      inexact = (rem != 0);
      invalid = (v < lo) || (v > hi);
    end
    pick = (nan || !sgn) ? hi : lo;
    o    = invalid ? pick[63:0] : v[63:0];
    if (t == T_U32 || t == T_I32) o = {{32{o[31]}}, o[31:0]};
    r.out     = o;
    r.flags   = invalid ? 5'b10000 : {4'b0000, inexact};
`ifdef RECF64_TO_ANY_BARREL_EN
    r.lat     = 1;
`else
    r.lat     = (!nan && !inf && !zero && e > 0 && e <= 63) ? 1 + (e + STEP - 1) / STEP : 1;
`endif
    r.acc_cyc = 0;
    return r;
  endfunction

  function automatic logic [64:0] rand_op();
    logic [63:0] r;
    logic [51:0] sg;
    logic [11:0] ex;
    int          k;
    r  = {$urandom(), $urandom()};
    sg = r[51:0];
    if ($urandom_range(0, 2) == 0) sg = sg & ({52{1'b1}} << $urandom_range(0, 52));
    k = int'($urandom_range(0, 19));
    case (k)
      0:       ex = {3'b000, 9'($urandom())};
      1:       ex = {3'b110, 9'($urandom())};
      2:       ex = {3'b111, 9'($urandom())};
      3:       ex = 12'($urandom_range(32'h200, 32'h7FC));
      4:       ex = 12'($urandom_range(32'h843, 32'hBFF));
      default: ex = 12'(2045 + int'($urandom_range(0, 69)));
    endcase
    return {1'($urandom()), ex, sg};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic issue(input logic [64:0] op, input logic [1:0] rmode, input logic [1:0] t, input int hold);
    exp_t x;
    int   waited = 0;
    while (!in_ready && waited < 500) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL in_ready_timeout: in_ready=0 after %0d cycles, expected 1", waited);
      return;
    end
    x          = model(op, rmode, t);
    force_hold = hold;
    in_valid   = 1'b1;
    in_op      = op;
    rm         = rmode;
    typ        = t;
    @(posedge clk);
    #1;
    x.acc_cyc = cyc;
    expq.push_back(x);
    @(negedge clk);
    in_valid = 1'b0;
    in_op    = {$urandom(), $urandom(), 1'b1};
    rm       = 2'($urandom());
    typ      = 2'($urandom());
  endtask

  initial begin : monitor
    exp_t cur;
    int   hold = 0;
    cur = '{default: 0};
    forever begin
      @(negedge clk);
      if (reset) begin
        mon_busy  = 0;
        out_ready = 1'b0;
      end else if (out_valid) begin
        if (!mon_busy) begin
          if (expq.size() == 0) begin
            compared++;
            mismatched++;
            $display("FAIL unexpected_output: got out=%h with no conversion pending", out);
            out_ready = 1'b1;
          end else begin
            cur      = expq.pop_front();
            mon_busy = 1;
            check("latency", 64'(cyc - cur.acc_cyc), 64'(cur.lat));
            hold       = (force_hold > 0) ? force_hold : int'($urandom_range(0, 2));
            force_hold = 0;
          end
        end
        if (mon_busy) begin
          check("out", out, cur.out);
          check("flags", 64'(flags), 64'(cur.flags));
          check("in_ready_in_done", 64'(in_ready), 64'd0);
          if (hold > 0) begin
            hold--;
            out_ready = 1'b0;
          end else begin
            out_ready = 1'b1;
            mon_busy  = 0;
          end
        end
      end else begin
        if (mon_busy) begin
          compared++;
          mismatched++;
          $display("FAIL valid_dropped: out_valid=0 before out_ready, expected 1");
          mon_busy = 0;
        end
        out_ready = 1'b0;
      end
    end
  end

  initial begin : driver
    int waited;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out", out, 64'd0);
    check("reset_flags", 64'(flags), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue({1'b0, 12'h800, 52'h0}, RNE, T_U64, 0);
    issue({1'b0, 12'h801, 52'h4000000000000}, RNE, T_I64, 0);
    issue({1'b0, 12'h801, 52'h4000000000000}, RMAX, T_I64, 0);
    issue({1'b1, 12'h800, 52'h8000000000000}, RMIN, T_I32, 0);
    issue({1'b1, 12'h800, 52'h8000000000000}, RMIN, T_U32, 0);
    issue({1'b0, 12'h83F, 52'h0}, RNE, T_I64, 0);
    issue({1'b0, 12'h83F, 52'h0}, RNE, T_U64, 0);
    issue({1'b1, 12'h83F, 52'h0}, RMAG, T_I64, 0);
    issue({1'b0, 12'hE00, 52'h0}, RNE, T_I32, 0);
    issue({1'b1, 12'hC00, 52'h0}, RNE, T_I64, 0);
    issue({1'b1, 12'h81F, 52'h0}, RNE, T_I32, 0);
    issue({1'b0, 12'h81F, 52'h0}, RNE, T_I32, 0);
    issue({1'b0, 12'h81F, 52'hFFFFFFFE00000}, RMAG, T_U32, 0);
    issue({1'b0, 12'h81F, 52'hFFFFFFFF00000}, RMAX, T_U32, 0);
    issue({1'b0, 12'h7FF, 52'h8000000000000}, RNE, T_U64, 0);
    issue({1'b1, 12'h7FF, 52'h0}, RNE, T_I64, 0);
    issue({1'b1, 12'h7F0, 52'h0}, RMIN, T_U64, 0);
    issue({1'b1, 12'h000, 52'h0}, RMIN, T_U32, 0);
    issue({1'b0, 12'h840, 52'h0}, RNE, T_U64, 0);

    issue({1'b0, 12'h800, 52'h0}, RNE, T_I64, 5);

`ifndef RECF64_TO_ANY_BARREL_EN
    waited = 0;
    while ((mon_busy || expq.size() != 0) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    issue({1'b0, 12'h83F, 52'h0}, RNE, T_U64, 0);
    @(negedge clk);
    check("busy_in_shift", 64'(in_ready), 64'd0);
    reset = 1'b1;
    void'(expq.pop_back());
    @(negedge clk);
    check("reset_mid_in_ready", 64'(in_ready), 64'd1);
    check("reset_mid_out_valid", 64'(out_valid), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    issue({1'b0, 12'h83F, 52'h0}, RNE, T_U64, 0);
`endif

    for (int i = 0; i < 300; i++) begin
      issue(rand_op(), 2'($urandom()), 2'($urandom()), 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    waited = 0;
    while ((mon_busy || expq.size() != 0) && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (mon_busy || expq.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: %0d results still pending, expected 0", expq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
